// File: rtl/mips_pkg.sv
// Shared definitions for the single-cycle MIPS core: opcodes, fetch FSM states
// and the default reset vector.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0040_0000;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        EXEC
    } fetch_state_t;

endpackage

// File: rtl/next_pc_sel.sv
// Next-PC selection: jump target, taken BEQ/BNE target, or sequential pc + 4.
module next_pc_sel (
    input  logic [31:0] pc_plus4,
    input  logic [31:0] instr,
    input  logic        branch,
    input  logic        xor_bne,
    input  logic        jump,
    input  logic        zero,
    output logic [31:0] next_pc
);

    logic [31:0] jump_target;
    logic [31:0] branch_target;
    logic        unused_opcode;

    assign jump_target   = {pc_plus4[31:28], instr[25:0], 2'b00};
    assign branch_target = pc_plus4 + {{14{instr[15]}}, instr[15:0], 2'b00};
    assign unused_opcode = ^instr[31:26];

    // Compare against 1'b1 so an undriven (z/x) decoder output falls through to pc + 4.
    always_comb begin
        next_pc = pc_plus4;
        if (jump == 1'b1) begin
            next_pc = jump_target;
        end else if (branch == 1'b1 && (zero ^ xor_bne) == 1'b1) begin
            next_pc = branch_target;
        end
    end

endmodule

// File: rtl/fetch_pc_unit.sv
// Fetch / PC stage: owns the PC, fetches over a req/ack instruction memory port
// and commits the next PC once the current instruction leaves EXEC.
module fetch_pc_unit
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic        instr_valid,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    input  logic        branch,
    input  logic        xor_bne,
    input  logic        jump,
    input  logic        zero,
    input  logic        exec_stall,
    output logic [31:0] retired
);

    fetch_state_t state_q, state_d;
    logic [31:0]  pc_q;
    logic [31:0]  instr_q;
    logic [31:0]  retired_q;
    logic [31:0]  next_pc;
    logic         fetch_done;
    logic         commit;

    assign fetch_done = (state_q == FETCH) && imem_ack;
    assign commit     = (state_q == EXEC) && !exec_stall;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = FETCH;
            FETCH:   if (imem_ack) state_d = EXEC;
            EXEC:    if (!exec_stall) state_d = FETCH;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            pc_q      <= RESET_PC;
            instr_q   <= 32'h0;
            retired_q <= 32'h0;
        end else begin
            state_q <= state_d;
            if (fetch_done) begin
                instr_q <= imem_rdata;
            end
            if (commit) begin
                pc_q      <= next_pc;
                retired_q <= retired_q + 32'd1;
            end
        end
    end

    next_pc_sel u_next_pc_sel (
        .pc_plus4 (pc_plus4),
        .instr    (instr_q),
        .branch   (branch),
        .xor_bne  (xor_bne),
        .jump     (jump),
        .zero     (zero),
        .next_pc  (next_pc)
    );

    // Handshake outputs come straight from the state register.
    assign imem_req    = (state_q == FETCH);
    assign instr_valid = (state_q == EXEC);
    assign imem_addr   = pc_q;
    assign pc          = pc_q;
    assign pc_plus4    = pc_q + 32'd4;
    assign instr       = instr_q;
    assign retired     = retired_q;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Directed bench for fetch_pc_unit: reset, sequential fetch, BEQ/BNE/J, waits and reset abort.
module tb_fetch_pc_unit;

    localparam logic [31:0] RST_PC = 32'h0040_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic        instr_valid;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        branch;
    logic        xor_bne;
    logic        jump;
    logic        zero;
    logic        exec_stall;
    logic [31:0] retired;

    int nvec = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    fetch_pc_unit #(.RESET_PC(RST_PC)) dut (
        .clk         (clk),
        .reset       (reset),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .instr       (instr),
        .instr_valid (instr_valid),
        .pc          (pc),
        .pc_plus4    (pc_plus4),
        .branch      (branch),
        .xor_bne     (xor_bne),
        .jump        (jump),
        .zero        (zero),
        .exec_stall  (exec_stall),
        .retired     (retired)
    );

    // Runs one instruction starting at a negedge in FETCH; ends at the negedge after commit.
    // stray drives exec_stall during FETCH and a bogus ack/rdata during EXEC.
    task automatic exec_one(input logic [31:0] word, input logic br, input logic xb,
                            input logic jmp, input logic z, input int ack_wait,
                            input int stall, input logic stray,
                            output int fetch_cyc, output int exec_cyc, output bit to);
        fetch_cyc = 0;
        exec_cyc  = 0;
        while (imem_req === 1'b1 && fetch_cyc < 50) begin
            imem_ack   = (fetch_cyc >= ack_wait);
            imem_rdata = word;
            exec_stall = stray;
            @(negedge clk);
            fetch_cyc++;
        end
        imem_ack   = 1'b0;
        exec_stall = 1'b0;
        branch     = br;
        xor_bne    = xb;
        jump       = jmp;
        zero       = z;
        while (instr_valid === 1'b1 && exec_cyc < 50) begin
            exec_stall = (exec_cyc < stall);
            imem_ack   = stray;
            imem_rdata = ~word;
            @(negedge clk);
            exec_cyc++;
        end
        imem_ack   = 1'b0;
        exec_stall = 1'b0;
        branch     = 1'b0;
        xor_bne    = 1'b0;
        jump       = 1'b0;
        zero       = 1'b0;
        to = (fetch_cyc == 0 || fetch_cyc >= 50 || exec_cyc == 0 || exec_cyc >= 50);
    endtask

    task automatic test_reset();
        reset = 1'b1; imem_ack = 1'b0; imem_rdata = 32'h0; exec_stall = 1'b0;
        branch = 1'b0; xor_bne = 1'b0; jump = 1'b0; zero = 1'b0;
        repeat (2) @(negedge clk);
        nvec++; if (imem_req !== 1'b0) begin nerr++; $display("FAIL rst_req got %b want 0", imem_req); end
        nvec++; if (instr_valid !== 1'b0) begin nerr++; $display("FAIL rst_valid got %b want 0", instr_valid); end
        nvec++; if (pc !== RST_PC) begin nerr++; $display("FAIL rst_pc got %h want %h", pc, RST_PC); end
        nvec++; if (imem_addr !== RST_PC) begin nerr++; $display("FAIL rst_addr got %h want %h", imem_addr, RST_PC); end
        nvec++; if (pc_plus4 !== 32'h0040_0004) begin nerr++; $display("FAIL rst_pc4 got %h want 00400004", pc_plus4); end
        nvec++; if (instr !== 32'h0) begin nerr++; $display("FAIL rst_instr got %h want 0", instr); end
        nvec++; if (retired !== 32'h0) begin nerr++; $display("FAIL rst_retired got %0d want 0", retired); end
        reset = 1'b0;
        #1;
        nvec++; if (imem_req !== 1'b0) begin nerr++; $display("FAIL idle_req got %b want 0", imem_req); end
        @(negedge clk);
        nvec++; if (imem_req !== 1'b1) begin nerr++; $display("FAIL first_req got %b want 1", imem_req); end
        nvec++; if (imem_addr !== RST_PC) begin nerr++; $display("FAIL first_addr got %h want %h", imem_addr, RST_PC); end
    endtask

    task automatic test_sequential();
        logic [31:0] exp_pc [4] = '{32'h0040_0004, 32'h0040_0008, 32'h0040_000C, 32'h0040_0010};
        int fc, ec;
        bit to;
        for (int i = 0; i < 4; i++) begin
            exec_one(32'h0000_0020, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0, fc, ec, to);
            nvec++; if (to) begin nerr++; $display("FAIL seq_timeout instr %0d", i); end
            nvec++; if (fc != 1 || ec != 1) begin
                nerr++; $display("FAIL seq_cycles got %0d/%0d want 1/1", fc, ec);
            end
            nvec++; if (pc !== exp_pc[i]) begin nerr++; $display("FAIL seq_pc got %h want %h", pc, exp_pc[i]); end
            nvec++; if (imem_req !== 1'b1) begin nerr++; $display("FAIL seq_req got %b want 1", imem_req); end
            if (i == 2) begin
                nvec++; if (retired !== 32'd3) begin nerr++; $display("FAIL seq_retired got %0d want 3", retired); end
            end
        end
    endtask

    task automatic test_branch();
        int fc, ec;
        bit to;
        exec_one({6'b000100, 5'd1, 5'd2, 16'hFFFC}, 1'b1, 1'b0, 1'b0, 1'b1, 0, 0, 1'b0, fc, ec, to);
        nvec++; if (to || pc !== 32'h0040_0004) begin nerr++; $display("FAIL beq_taken got %h want 00400004", pc); end
        exec_one({6'b000010, 26'h0100004}, 1'b1, 1'b0, 1'b1, 1'b0, 0, 0, 1'b0, fc, ec, to);
        nvec++; if (to || pc !== 32'h0040_0010) begin nerr++; $display("FAIL j_back got %h want 00400010", pc); end
        exec_one({6'b000100, 5'd1, 5'd2, 16'hFFFC}, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0, fc, ec, to);
        nvec++; if (to || pc !== 32'h0040_0014) begin nerr++; $display("FAIL beq_not got %h want 00400014", pc); end
        exec_one({6'b000101, 5'd1, 5'd2, 16'h0003}, 1'b1, 1'b1, 1'b0, 1'b0, 0, 0, 1'b0, fc, ec, to);
        nvec++; if (to || pc !== 32'h0040_0024) begin nerr++; $display("FAIL bne_taken got %h want 00400024", pc); end
        exec_one({6'b000101, 5'd1, 5'd2, 16'h0003}, 1'b1, 1'b1, 1'b0, 1'b1, 0, 0, 1'b0, fc, ec, to);
        nvec++; if (to || pc !== 32'h0040_0028) begin nerr++; $display("FAIL bne_not got %h want 00400028", pc); end
    endtask

    task automatic test_jump();
        int fc, ec;
        bit to;
        for (int i = 0; i < 2; i++) begin
            exec_one({6'b000010, 26'h0100008}, 1'b1, 1'b0, 1'b1, 1'b1, 0, 0, 1'b0, fc, ec, to);
            nvec++; if (to || pc !== 32'h0040_0020) begin
                nerr++; $display("FAIL jump_%0d got %h want 00400020", i, pc);
            end
        end
        nvec++; if (retired !== 32'd11) begin nerr++; $display("FAIL jump_retired got %0d want 11", retired); end
    endtask

    task automatic test_wait_stall();
        int fc, ec;
        bit to;
        exec_one(32'h0123_4567, 1'b0, 1'b0, 1'b0, 1'b0, 3, 2, 1'b1, fc, ec, to);
        nvec++; if (to) begin nerr++; $display("FAIL wait_timeout"); end
        nvec++; if (fc != 4) begin nerr++; $display("FAIL wait_fetch got %0d want 4", fc); end
        nvec++; if (ec != 3) begin nerr++; $display("FAIL wait_exec got %0d want 3", ec); end
        nvec++; if (instr !== 32'h0123_4567) begin nerr++; $display("FAIL wait_instr got %h want 01234567", instr); end
        nvec++; if (pc !== 32'h0040_0024) begin nerr++; $display("FAIL wait_pc got %h want 00400024", pc); end
        nvec++; if (retired !== 32'd12) begin nerr++; $display("FAIL wait_retired got %0d want 12", retired); end
    endtask

    task automatic test_reset_mid_exec();
        imem_ack = 1'b1;
        imem_rdata = 32'h0000_0020;
        @(negedge clk);
        imem_ack = 1'b0;
        exec_stall = 1'b1;
        @(negedge clk);
        nvec++; if (instr_valid !== 1'b1) begin nerr++; $display("FAIL abort_setup got %b want 1", instr_valid); end
        reset = 1'b1;
        #1;
        nvec++; if (imem_req !== 1'b0) begin nerr++; $display("FAIL abort_req got %b want 0", imem_req); end
        nvec++; if (instr_valid !== 1'b0) begin nerr++; $display("FAIL abort_valid got %b want 0", instr_valid); end
        nvec++; if (pc !== RST_PC) begin nerr++; $display("FAIL abort_pc got %h want %h", pc, RST_PC); end
        nvec++; if (retired !== 32'd0) begin nerr++; $display("FAIL abort_retired got %0d want 0", retired); end
        @(negedge clk);
        exec_stall = 1'b0;
        reset = 1'b0;
        @(negedge clk);
        nvec++; if (imem_req !== 1'b1 || imem_addr !== RST_PC) begin
            nerr++; $display("FAIL abort_restart got %b/%h want 1/%h", imem_req, imem_addr, RST_PC);
        end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_branch();
        test_jump();
        test_wait_stall();
        test_reset_mid_exec();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/fetch_pc_unit.md
# fetch_pc_unit

Instruction fetch and program-counter stage of the single-cycle MIPS core, directly upstream of the main control decoder. It owns the PC register and fetches each instruction from a handshaked instruction memory. It presents the instruction so `instr[31:26]` drives the decoder's `Opcode`. It then consumes the decoder's `Branch`, `XorBne` and `Jump` outputs, plus the ALU `Zero` flag, to select and commit the next PC.

## Interface
- `RESET_PC`, default 32'h0040_0000: PC value loaded on reset; must be word-aligned.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `imem_req`  out  1  fetch request, high in FETCH state only.
- `imem_addr`  out  32  byte address of the fetch, equal to `pc`.
- `imem_ack`  in  1  instruction memory has accepted the request and returns data this cycle.
- `imem_rdata`  in  32  instruction word, valid when `imem_ack`.
- `instr`  out  32  latched instruction; `[31:26]` drives the decoder's `Opcode`.
- `instr_valid`  out  1  high in EXEC state; downstream writes (regfile, dmem) qualify with it.
- `pc`  out  32  current PC.
- `pc_plus4`  out  32  `pc + 4`.
- `branch`, `xor_bne`, `jump`  in  1 each  from the control decoder.
- `zero`  in  1  ALU zero flag for the current instruction.
- `exec_stall`  in  1  holds EXEC, e.g. while data memory is busy.
- `retired`  out  32  count of committed instructions.

## Operation
- FSM states: IDLE, FETCH, EXEC.
  - IDLE goes to FETCH unconditionally.
  - FETCH stays in FETCH until `imem_ack`. On ack: `instr <= imem_rdata`, then go to EXEC.
  - EXEC stays in EXEC while `exec_stall`. Otherwise it commits: `pc <= next_pc`, `retired <= retired + 1`, then go to FETCH.
- next_pc priority, evaluated only at commit:
  - `jump` = 1: `{pc_plus4[31:28], instr[25:0], 2'b00}`. This takes priority because the decoder asserts `branch` together with `jump`.
  - Else if `branch & (zero ^ xor_bne)`: `pc_plus4 + {{14{instr[15]}}, instr[15:0], 2'b00}`. This covers BEQ (taken when zero = 1) and BNE (taken when zero = 0).
  - Otherwise: `pc_plus4`.
- Arithmetic is 32-bit modulo 2^32. PC wrap from 32'hFFFF_FFFC goes to 0 with no flag.
- `retired` wraps from 32'hFFFF_FFFF to 0.
- On undefined opcodes the decoder drives z. In that case the unit treats `branch`/`jump` as 0 (not equal to 1) and commits `pc_plus4`.
- Boundary cases:
  - `imem_ack` outside FETCH is ignored.
  - `exec_stall` outside EXEC is ignored.
  - `reset` mid-fetch or mid-EXEC aborts immediately. No commit occurs and `imem_req` drops asynchronously.

## Timing
- Reset values: state IDLE, `pc` = RESET_PC, `instr` = 0, `instr_valid` = 0, `imem_req` = 0, `retired` = 0. `imem_addr` = RESET_PC and `pc_plus4` = RESET_PC + 4.
- `imem_req` and `instr_valid` are decoded from the state register only. They have no combinational path from any input.
- With zero-wait memory (ack in the first FETCH cycle), each instruction takes 2 cycles: one FETCH, one EXEC.
- Each memory wait cycle or `exec_stall` cycle adds one cycle.
- The first `imem_req` is asserted in the 2nd cycle after reset deassertion (IDLE lasts one cycle).
- The new `pc` is visible in the cycle after commit, together with `imem_req` = 1.

## Structure
- Shared package `mips_pkg` holds:
  - opcode constants: OP_RTYPE 6'b000000, OP_LW 6'b100011, OP_SW 6'b101011, OP_BEQ 6'b000100, OP_BNE 6'b000101, OP_J 6'b000010;
  - the `fetch_state_t` enum (IDLE, FETCH, EXEC);
  - the default RESET_PC.
- One combinational sub-module, `next_pc_sel`. Inputs: `pc_plus4`, `instr`, `branch`, `xor_bne`, `jump`, `zero`. Output: `next_pc`.

## Test plan
- Reset with RESET_PC = 32'h0040_0000, ack always high → `imem_req` rises in cycle 2 with `imem_addr` = 32'h0040_0000; PC sequence 0x00400000, 0x00400004, 0x00400008; `retired` = 3 after 6 cycles.
- BEQ at 0x00400010, imm 16'hFFFC, branch = 1, zero = 1 → next `pc` = 0x00400004. Same with zero = 0 → 0x00400014.
- BNE (xor_bne = 1), imm 16'h0003, zero = 0 → `pc` = pc + 4 + 12. With zero = 1 → pc + 4.
- J at 0x00400020 with instr[25:0] = 26'h0100008, branch = 1 and jump = 1 → `pc` = 0x00400020.
- Ack delayed 3 cycles, plus `exec_stall` held 2 cycles → FETCH lasts 4 cycles, EXEC lasts 3, one commit. A spurious ack during EXEC leaves `instr` unchanged.
- Assert `reset` during EXEC with a stall active → `pc` = RESET_PC, `retired` = 0, `instr_valid` = 0 and `imem_req` = 0 before the next clock edge.
